counter_seq_ctrl: RTL



---
 rtl/counter_seq_ctrl_pkg.sv | 19 +
 rtl/counter_seq_ctrl_if.sv | 29 ++
 rtl/counter_seq_ctrl_stage.sv | 29 ++
 rtl/counter_seq_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the cascaded 4-bit counter sequencer.
package cnt_seq_pkg;

  // Width of one counter stage; the chain width is STAGE_W * STAGES.
  localparam int STAGE_W = 4;

  // Controller states (2-bit encoding).
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Values of the mode strap, sampled at each terminal event.
  localparam logic M_ONESHOT = 1'b0;
  localparam logic M_RELOAD  = 1'b1;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle of the counter sequencer. The master side requests
// start/stop/pause and supplies the preset; the slave side reports the count.
interface counter_seq_ctrl_if
  import cnt_seq_pkg::*;
#(
  parameter int STAGES = 2
);
  localparam int W = STAGE_W * STAGES;

  logic         start;
  logic         stop;
  logic         pause;
  logic         mode;
  logic [W-1:0] preset;
  logic [W-1:0] q;
  logic         co;
  logic         busy;
  logic         done;

  modport master (
    output start, stop, pause, mode, preset,
    input  q, co, busy, done
  );

  modport slave (
    input  start, stop, pause, mode, preset,
    output q, co, busy, done
  );
endinterface

// File: rtl/counter_seq_ctrl_stage.sv
// One 4-bit synchronous counter stage: clear beats load beats enable.
// CO is combinational so the next stage can see it on the same edge.
module cnt4_sync_stage
  import cnt_seq_pkg::*;
(
  input  logic               CLK,
  input  logic               clr,
  input  logic               load,
  input  logic               en,
  input  logic [STAGE_W-1:0] d,
  output logic [STAGE_W-1:0] q,
  output logic               co
);
  logic [STAGE_W-1:0] q_reg;

  // Stage register: clear, parallel load, or increment by one.
  always_ff @(posedge CLK) begin
    if (clr) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end else if (en) begin
      q_reg <= q_reg + STAGE_W'(1);
    end
  end

  assign q  = q_reg;
  assign co = &q_reg;
endmodule

// File: rtl/counter_seq_ctrl.sv
// Timer/sequencer around a chain of 4-bit counter stages: loads a preset,
// counts up to all ones, then stops (one-shot) or reloads (auto-reload).
// Supports pause, abort (stop) and restart (start while active).
module counter_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int STAGES   = 2,
  parameter int MODE_DEF = 0   // documents the board's default mode strap
)(
  input  logic               CLK,
  input  logic               RST,
  counter_seq_ctrl_if.slave  bus
);
  localparam int W = STAGE_W * STAGES;

  // MODE_DEF carries no logic; a non-0/1 value leaves this marker block in
  // the elaborated hierarchy so a bad strap setting is easy to spot.
  if (MODE_DEF != 0 && MODE_DEF != 1) begin : g_mode_def_out_of_range
  end

  state_t state_reg, state_next;
  logic   busy_reg, busy_next;
  logic   done_reg, done_next;

  logic   clr;
  logic   load;
  logic   cnt_en;
  logic   terminal;

  logic [W-1:0]      q;
  logic [STAGES-1:0] stage_co;
  logic [STAGES-1:0] stage_en;

  // Ripple-enable carry chain: a stage counts only when every lower stage
  // is at all ones. All stages share the same clock, so it stays synchronous.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_en[gi] = cnt_en;
    end else begin : g_rest
      assign stage_en[gi] = stage_en[gi-1] & stage_co[gi-1];
    end

    cnt4_sync_stage u_stage (
      .CLK  (CLK),
      .clr  (clr),
      .load (load),
      .en   (stage_en[gi]),
      .d    (bus.preset[gi*STAGE_W +: STAGE_W]),
      .q    (q[gi*STAGE_W +: STAGE_W]),
      .co   (stage_co[gi])
    );
  end

  assign terminal = &stage_co;

  // Next-state and chain controls; priority RST > STOP > START > terminal/count > PAUSE.
  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    clr        = 1'b0;
    load       = 1'b0;
    cnt_en     = 1'b0;

    if (RST) begin
      clr        = 1'b1;
      state_next = S_IDLE;
      busy_next  = 1'b0;
    end else if (bus.stop) begin
      state_next = S_IDLE;
      busy_next  = 1'b0;
    end else if (bus.start) begin
      load       = 1'b1;
      state_next = S_RUN;
      busy_next  = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_IDLE;
        end
        S_RUN: begin
          if (terminal) begin
            // Terminal takes precedence over a same-edge pause request.
            done_next = 1'b1;
            if (bus.mode == M_RELOAD) begin
              load = 1'b1;
            end else begin
              state_next = S_DONE;
              busy_next  = 1'b0;
            end
          end else if (bus.pause) begin
            state_next = S_PAUSED;
          end else begin
            cnt_en = 1'b1;
          end
        end
        S_PAUSED: begin
          if (!bus.pause) begin
            state_next = S_RUN;
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end
        default: begin
          state_next = S_IDLE;
          busy_next  = 1'b0;
        end
      endcase
    end
  end

  // Controller state and registered status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.q    = q;
  assign bus.co   = terminal;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
endmodule
